// File: rtl/iram_boot_loader_pkg.sv
// Shared types and helpers for the instruction RAM boot loader.
// Optional build macro: IRAM_PARITY_EN (parity-protected word storage).
package iram_pkg;

   // Load sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   // Widest word the parity helper accepts; narrower words are zero-extended,
   // which leaves their parity unchanged.
   localparam int PAR_MAX_W = 256;

   // Bytes per instruction word
   function automatic int nbytes(input int data_w);
      return data_w / 8;
   endfunction

   // Even parity bit: makes the total count of ones (data + parity) even
   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/iram_boot_loader_if.sv
// Fetch and boot-load signal bundle for the instruction RAM.
// The processor/host side uses the master modport, the RAM uses slave.
// Optional build macro: IRAM_PARITY_EN (par_err is present in both builds).
interface iram_boot_loader_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
);
   // Fetch side
   logic              fetch_en;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] q;
   logic              q_valid;
   logic              par_err;

   // Boot-load side
   logic              ld_start;
   logic              ld_valid;
   logic [7:0]        ld_byte;
   logic              ld_last;
   logic              ld_ready;
   logic [ADDR_W:0]   ld_count;
   logic              ld_done;
   logic              ld_ovf;
   logic              busy;

   modport master (
      output fetch_en, address, ld_start, ld_valid, ld_byte, ld_last,
      input  q, q_valid, par_err, ld_ready, ld_count, ld_done, ld_ovf, busy
   );

   modport slave (
      input  fetch_en, address, ld_start, ld_valid, ld_byte, ld_last,
      output q, q_valid, par_err, ld_ready, ld_count, ld_done, ld_ovf, busy
   );

endinterface

// File: rtl/iram_byte_packer.sv
// Assembles an incoming byte stream into DATA_W words, MSB byte first.
// word_valid/word_data are combinational with the completing byte so the
// word can be written on the same edge that accepts that byte.
// A last byte on a partial word emits the word with low bytes zero.
// Optional build macro: IRAM_PARITY_EN (not used inside this block).
module iram_byte_packer
   import iram_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   input  logic              byte_last,
   output logic              word_valid,
   output logic [DATA_W-1:0] word_data
);

   localparam int NBYTES = nbytes(DATA_W);
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] merged;

   // Drop the current byte into its lane; lanes not yet filled stay zero in
   // acc_q, which provides the zero fill on a short final word.
   generate
      for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
         assign merged[DATA_W-1-8*gi -: 8] = (idx_q == IDX_W'(gi)) ?
                                             byte_data : acc_q[DATA_W-1-8*gi -: 8];
      end
   endgenerate

   assign word_valid = byte_valid & (byte_last | (idx_q == IDX_LAST));
   assign word_data  = merged;

   // Next accumulator/index: restart after every emitted word or on clear
   always_comb begin
      idx_d = idx_q;
      acc_d = acc_q;
      if (clear) begin
         idx_d = '0;
         acc_d = '0;
      end else if (byte_valid) begin
         if (word_valid) begin
            idx_d = '0;
            acc_d = '0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
            acc_d = merged;
         end
      end
   end

   // Packer state registers
   always_ff @(posedge clock) begin
      if (reset) begin
         idx_q <= '0;
         acc_q <= '0;
      end else begin
         idx_q <= idx_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/iram_boot_loader.sv
// Parametrised instruction RAM with a byte-stream boot-load port.
// Loads pack bytes into words written sequentially from address 0; the
// fetch port gives a registered read and is refused while a load runs.
// Optional build macro: IRAM_PARITY_EN -- store an even-parity bit per
// word and flag mismatches on fetch via par_err; otherwise par_err is 0.
module iram_boot_loader
   import iram_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input logic                clock,
   input logic                reset,
   iram_boot_loader_if.slave  bus
);

   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
`ifdef IRAM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif

   // Word storage; deliberately never cleared so reset keeps the image
   logic [MEM_W-1:0] mem [DEPTH];

   state_t          state_q, state_d;
   logic [ADDR_W:0] ld_count_q, ld_count_d;
   logic            ld_ovf_q, ld_ovf_d;
   logic            ld_done_q, ld_done_d;

   logic [DATA_W-1:0] q_q;
   logic              q_valid_q;
   logic              par_err_q;

   logic              byte_acc;
   logic              pack_clear;
   logic              word_valid;
   logic [DATA_W-1:0] word_data;
   logic              mem_full;
   logic              wr_en;
   logic [MEM_AW-1:0] wr_idx;
   logic [MEM_W-1:0]  wr_word;
   logic              fetch_acc;
   logic              rd_in_range;
   logic [MEM_AW-1:0] rd_idx;

   assign byte_acc   = bus.ld_valid & (state_q == LOAD);
   assign pack_clear = (state_q == IDLE) & bus.ld_start;

   iram_byte_packer #(
      .DATA_W (DATA_W)
   ) u_packer (
      .clock      (clock),
      .reset      (reset),
      .clear      (pack_clear),
      .byte_valid (byte_acc),
      .byte_data  (bus.ld_byte),
      .byte_last  (bus.ld_last),
      .word_valid (word_valid),
      .word_data  (word_data)
   );

   // ld_count doubles as the write pointer: every written word advances it,
   // and once it reaches DEPTH further completed words are discarded.
   assign mem_full = (ld_count_q == DEPTH_L);
   assign wr_en    = word_valid & ~mem_full;
   assign wr_idx   = ld_count_q[MEM_AW-1:0];

`ifdef IRAM_PARITY_EN
   assign wr_word = {even_parity(PAR_MAX_W'(word_data)), word_data};
`else
   assign wr_word = word_data;
`endif

   assign fetch_acc   = bus.fetch_en & (state_q == IDLE);
   assign rd_in_range = ({1'b0, bus.address} < DEPTH_L);
   assign rd_idx      = bus.address[MEM_AW-1:0];

   // Load sequencer next-state: counters, overflow flag and done strobe
   always_comb begin
      state_d    = state_q;
      ld_count_d = ld_count_q;
      ld_ovf_d   = ld_ovf_q;
      ld_done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.ld_start) begin
               state_d    = LOAD;
               ld_count_d = '0;
               ld_ovf_d   = 1'b0;
            end
         end
         LOAD: begin
            if (byte_acc) begin
               if (word_valid) begin
                  if (mem_full) begin
                     ld_ovf_d = 1'b1;
                  end else begin
                     ld_count_d = ld_count_q + (ADDR_W + 1)'(1);
                  end
               end
               if (bus.ld_last) begin
                  state_d   = DONE;
                  ld_done_d = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Load sequencer registers (state plus registered status outputs)
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         ld_count_q <= '0;
         ld_ovf_q   <= 1'b0;
         ld_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ld_count_q <= ld_count_d;
         ld_ovf_q   <= ld_ovf_d;
         ld_done_q  <= ld_done_d;
      end
   end

   // Single write port, fed by the packer on the completing byte's edge
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_word;
      end
   end

   // Registered read port; q holds between accepted fetches and reads
   // beyond the implemented depth return zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         q_q       <= '0;
         q_valid_q <= 1'b0;
         par_err_q <= 1'b0;
      end else begin
         q_valid_q <= fetch_acc;
         par_err_q <= 1'b0;
         if (fetch_acc) begin
            if (rd_in_range) begin
               q_q <= mem[rd_idx][DATA_W-1:0];
`ifdef IRAM_PARITY_EN
               par_err_q <= ^mem[rd_idx];
`endif
            end else begin
               q_q <= '0;
            end
         end
      end
   end

   assign bus.q        = q_q;
   assign bus.q_valid  = q_valid_q;
   assign bus.par_err  = par_err_q;
   assign bus.ld_ready = (state_q == LOAD);
   assign bus.ld_count = ld_count_q;
   assign bus.ld_done  = ld_done_q;
   assign bus.ld_ovf   = ld_ovf_q;
   assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_iram_boot_loader.sv
// Bench for iram_boot_loader: a 256-word and a 4-word instance share one
// stimulus bus; fetch results are checked through per-instance queues.
// Optional build macro: IRAM_PARITY_EN enables the parity corruption case.
`timescale 1ns/1ps
module tb_iram_boot_loader;

   typedef struct packed {
      logic [15:0] q;
      logic        par;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   // Shared stimulus, steered to one instance by sel_small
   logic       sel_small;
   logic       ld_start, ld_valid, ld_last, fetch_en;
   logic [7:0] ld_byte, address;

   iram_boot_loader_if #(.DATA_W(16), .ADDR_W(8)) bus_a ();
   iram_boot_loader_if #(.DATA_W(16), .ADDR_W(8)) bus_s ();

   assign bus_a.fetch_en = fetch_en & ~sel_small;
   assign bus_a.address  = address;
   assign bus_a.ld_start = ld_start & ~sel_small;
   assign bus_a.ld_valid = ld_valid & ~sel_small;
   assign bus_a.ld_byte  = ld_byte;
   assign bus_a.ld_last  = ld_last;
   assign bus_s.fetch_en = fetch_en & sel_small;
   assign bus_s.address  = address;
   assign bus_s.ld_start = ld_start & sel_small;
   assign bus_s.ld_valid = ld_valid & sel_small;
   assign bus_s.ld_byte  = ld_byte;
   assign bus_s.ld_last  = ld_last;

   iram_boot_loader #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) dut_a (
      .clock (clock),
      .reset (reset),
      .bus   (bus_a)
   );

   iram_boot_loader #(.DATA_W(16), .ADDR_W(8), .DEPTH(4)) dut_s (
      .clock (clock),
      .reset (reset),
      .bus   (bus_s)
   );

   int checks   = 0;
   int failures = 0;

   logic [15:0] model_a [256];
   logic [15:0] model_s [4];
   exp_t        exp_a [$];
   exp_t        exp_s [$];
   logic [7:0]  bq [$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Scoreboard consumers: every q_valid pulse must match the oldest expectation
   always @(posedge clock) begin : mon_a
      exp_t e;
      #1;
      if (bus_a.q_valid) begin
         if (exp_a.size() == 0) begin
            check_val("qv_a_unexpected", 1, 0);
         end else begin
            e = exp_a.pop_front();
            check_val("q_a", {16'h0, bus_a.q}, {16'h0, e.q});
            check_val("par_a", {31'h0, bus_a.par_err}, {31'h0, e.par});
            $display("fetch A q=%04h par=%0d", bus_a.q, bus_a.par_err);
         end
      end
   end

   always @(posedge clock) begin : mon_s
      exp_t e;
      #1;
      if (bus_s.q_valid) begin
         if (exp_s.size() == 0) begin
            check_val("qv_s_unexpected", 1, 0);
         end else begin
            e = exp_s.pop_front();
            check_val("q_s", {16'h0, bus_s.q}, {16'h0, e.q});
            $display("fetch S q=%04h", bus_s.q);
         end
      end
   end

   // Expected fetch result from the bench's own image model
   task automatic push_exp(input bit sm, input int addr, input bit par);
      exp_t e;
      int   depth = sm ? 4 : 256;
      e.par = par;
      if (addr >= depth) e.q = 16'h0;
      else if (sm)       e.q = model_s[addr];
      else               e.q = model_a[addr];
      if (sm) exp_s.push_back(e);
      else    exp_a.push_back(e);
   endtask

   task automatic do_fetch(input bit sm, input int addr, input bit par);
      @(negedge clock);
      sel_small = sm;
      fetch_en  = 1'b1;
      address   = addr[7:0];
      push_exp(sm, addr, par);
   endtask

   task automatic fetch_off();
      @(negedge clock);
      fetch_en = 1'b0;
   endtask

   // Full load: start, stream bytes, check done pulse, then update the model.
   // start_fetch >= 0 issues a fetch in the ld_start cycle; fetch_busy keeps
   // fetch_en high while loading (those fetches must be refused).
   task automatic do_load(input bit sm, input logic [7:0] bytes[$],
                          input int start_fetch, input bit fetch_busy);
      int n     = bytes.size();
      int depth = sm ? 4 : 256;
      logic [15:0] w;
      @(negedge clock);
      sel_small = sm;
      ld_start  = 1'b1;
      if (start_fetch >= 0) begin
         fetch_en = 1'b1;
         address  = start_fetch[7:0];
         push_exp(sm, start_fetch, 1'b0);
      end else begin
         fetch_en = 1'b0;
      end
      @(negedge clock);
      ld_start = 1'b0;
      fetch_en = fetch_busy;
      address  = 8'h0;
      check_val("ld_ready_load", {31'h0, sm ? bus_s.ld_ready : bus_a.ld_ready}, 1);
      check_val("busy_load", {31'h0, sm ? bus_s.busy : bus_a.busy}, 1);
      for (int i = 0; i < n; i++) begin
         ld_valid = 1'b1;
         ld_byte  = bytes[i];
         ld_last  = (i == n - 1);
         @(negedge clock);
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      fetch_en = 1'b0;
      check_val("ld_done_pulse", {31'h0, sm ? bus_s.ld_done : bus_a.ld_done}, 1);
      check_val("ld_ready_done", {31'h0, sm ? bus_s.ld_ready : bus_a.ld_ready}, 0);
      @(negedge clock);
      check_val("ld_done_end", {31'h0, sm ? bus_s.ld_done : bus_a.ld_done}, 0);
      check_val("busy_end", {31'h0, sm ? bus_s.busy : bus_a.busy}, 0);
      for (int wi = 0; wi < (n + 1) / 2; wi++) begin
         w = {bytes[2*wi], (2*wi + 1 < n) ? bytes[2*wi + 1] : 8'h00};
         if (wi < depth) begin
            if (sm) model_s[wi] = w;
            else    model_a[wi] = w;
         end
      end
      $display("load %s bytes=%0d count=%0d ovf=%0d", sm ? "S" : "A", n,
               sm ? bus_s.ld_count : bus_a.ld_count, sm ? bus_s.ld_ovf : bus_a.ld_ovf);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; sel_small = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
      ld_last = 1'b0; ld_byte = 8'h0; fetch_en = 1'b0; address = 8'h0;
      repeat (3) @(negedge clock);
      check_val("rst_q", {16'h0, bus_a.q}, 0);
      check_val("rst_q_valid", {31'h0, bus_a.q_valid}, 0);
      check_val("rst_ld_ready", {31'h0, bus_a.ld_ready}, 0);
      check_val("rst_ld_count", {23'h0, bus_a.ld_count}, 0);
      check_val("rst_ld_done", {31'h0, bus_a.ld_done}, 0);
      check_val("rst_ld_ovf", {31'h0, bus_a.ld_ovf}, 0);
      check_val("rst_par_err", {31'h0, bus_a.par_err}, 0);
      check_val("rst_busy", {31'h0, bus_a.busy}, 0);
      reset = 1'b0;

      // Two full words
      bq.delete();
      bq.push_back(8'h12); bq.push_back(8'h34); bq.push_back(8'h56); bq.push_back(8'h78);
      do_load(1'b0, bq, -1, 1'b0);
      check_val("t1_ld_count", {23'h0, bus_a.ld_count}, 2);
      check_val("t1_ld_ovf", {31'h0, bus_a.ld_ovf}, 0);

      // Back-to-back fetches
      do_fetch(1'b0, 0, 1'b0);
      do_fetch(1'b0, 1, 1'b0);
      do_fetch(1'b0, 0, 1'b0);
      fetch_off();
      @(negedge clock);
      check_val("t2_qv_low", {31'h0, bus_a.q_valid}, 0);

      // Partial last word; fetch with ld_start served, fetches while loading refused
      bq.delete();
      bq.push_back(8'hAA); bq.push_back(8'hBB); bq.push_back(8'hCC);
      do_load(1'b0, bq, 1, 1'b1);
      check_val("t3_q_hold", {16'h0, bus_a.q}, 32'h5678);
      check_val("t3_ld_count", {23'h0, bus_a.ld_count}, 2);
      do_fetch(1'b0, 1, 1'b0);
      do_fetch(1'b0, 0, 1'b0);
      fetch_off();

      // Overflow on the 4-word instance
      bq.delete();
      for (int i = 1; i <= 10; i++) bq.push_back(8'(i));
      do_load(1'b1, bq, -1, 1'b0);
      check_val("t4_ld_count", {23'h0, bus_s.ld_count}, 4);
      check_val("t4_ld_ovf", {31'h0, bus_s.ld_ovf}, 1);
      for (int i = 0; i < 4; i++) do_fetch(1'b1, i, 1'b0);
      do_fetch(1'b1, 5, 1'b0);
      do_fetch(1'b1, 255, 1'b0);
      fetch_off();
      bq.delete();
      bq.push_back(8'hEE); bq.push_back(8'hFF);
      do_load(1'b1, bq, -1, 1'b0);
      check_val("t4_ovf_cleared", {31'h0, bus_s.ld_ovf}, 0);
      check_val("t4_count_new", {23'h0, bus_s.ld_count}, 1);
      do_fetch(1'b1, 0, 1'b0);
      fetch_off();

      // Reset in the middle of a load
      @(negedge clock);
      sel_small = 1'b0;
      ld_start  = 1'b1;
      @(negedge clock);
      ld_start = 1'b0;
      ld_valid = 1'b1; ld_byte = 8'h9A; @(negedge clock);
      ld_byte = 8'hBC; @(negedge clock);
      ld_byte = 8'hDE; @(negedge clock);
      ld_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      model_a[0] = 16'h9ABC;
      check_val("t5_busy", {31'h0, bus_a.busy}, 0);
      check_val("t5_ld_ready", {31'h0, bus_a.ld_ready}, 0);
      check_val("t5_ld_count", {23'h0, bus_a.ld_count}, 0);
      do_fetch(1'b0, 0, 1'b0);
      do_fetch(1'b0, 1, 1'b0);
      fetch_off();

`ifdef IRAM_PARITY_EN
      // Corrupt the stored parity bit of word 2 only
      bq.delete();
      for (int i = 1; i <= 6; i++) bq.push_back(8'(8'h11 * i));
      do_load(1'b0, bq, -1, 1'b0);
      dut_a.mem[2][16] = ~dut_a.mem[2][16];
      do_fetch(1'b0, 2, 1'b1);
      do_fetch(1'b0, 1, 1'b0);
      fetch_off();
`endif

      repeat (3) @(negedge clock);
      check_val("sb_a_empty", exp_a.size(), 0);
      check_val("sb_s_empty", exp_s.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
